// File: rtl/gpr_exec_unit.sv
// Multi-cycle execute unit: GPR bank, special register (mul high half) and status flags.
// Single-cycle mov/add/sub, shift-add multiplier one bit per cycle, illegal-opcode detect.
module gpr_exec_unit #(
  parameter int DATA_W     = 16,
  parameter int GPR_DEPTH  = 32,
  parameter bit IMM_SIGNED = 1'b0
) (
  input  logic              clk,
  input  logic              sys_rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [31:0]       instr_in,
  output logic              done,
  output logic              illegal,
  output logic [3:0]        flags,
  input  logic [4:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [DATA_W-1:0] sgpr
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_MUL  = 2'd2;

  localparam logic [4:0] OP_MOVSGPR = 5'd0;
  localparam logic [4:0] OP_MOV     = 5'd1;
  localparam logic [4:0] OP_ADD     = 5'd2;
  localparam logic [4:0] OP_SUB     = 5'd3;
  localparam logic [4:0] OP_MUL     = 5'd4;

  localparam int              CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  logic [1:0]          state;
  logic [4:0]          op;
  logic [4:0]          rdst;
  logic                imm_mode;
  logic [DATA_W-1:0]   op_a, op_b;
  logic [CNT_W-1:0]    cnt;
  logic [2*DATA_W-1:0] prod, prod_nxt;
  logic [DATA_W:0]     mul_add;

  // Entries at or above GPR_DEPTH are never written and stay at their reset value 0,
  // so out-of-range reads return 0 and out-of-range writes vanish.
  logic [DATA_W-1:0]   regs [32];

  logic                issue;
  logic [DATA_W-1:0]   imm_ext, b_nxt;
  logic [DATA_W:0]     sum, diff;

  logic                wr_en, sgpr_we, flag_we;
  logic [DATA_W-1:0]   wr_data;
  logic [3:0]          flag_nxt;

  assign instr_ready = (state == S_IDLE);
  assign issue       = instr_valid & instr_ready;
  assign dbg_data    = regs[dbg_addr];

  assign imm_ext = IMM_SIGNED ? DATA_W'($signed(instr_in[15:0])) : DATA_W'(instr_in[15:0]);
  assign b_nxt   = instr_in[16] ? imm_ext : regs[instr_in[15:11]];

  assign sum  = {1'b0, op_a} + {1'b0, op_b};
  assign diff = {1'b0, op_a} - {1'b0, op_b};

  // Multiplier in low half of prod is consumed LSB first while partial sums enter the top.
  assign mul_add  = {1'b0, prod[2*DATA_W-1:DATA_W]} + (prod[0] ? {1'b0, op_a} : '0);
  assign prod_nxt = {mul_add, prod[DATA_W-1:1]};

  always_comb begin
    wr_en    = 1'b0;
    sgpr_we  = 1'b0;
    flag_we  = 1'b0;
    wr_data  = '0;
    flag_nxt = flags;
    if (state == S_EXEC) begin
      case (op)
        OP_MOVSGPR: begin
          wr_en = 1'b1; flag_we = 1'b1; wr_data = sgpr;
          flag_nxt = {sgpr[DATA_W-1], sgpr == '0, 2'b00};
        end
        OP_MOV: begin
          wr_en = 1'b1; flag_we = 1'b1;
          wr_data = imm_mode ? op_b : op_a;
          flag_nxt = {wr_data[DATA_W-1], wr_data == '0, 2'b00};
        end
        OP_ADD: begin
          wr_en = 1'b1; flag_we = 1'b1; wr_data = sum[DATA_W-1:0];
          flag_nxt = {wr_data[DATA_W-1], wr_data == '0, sum[DATA_W],
                      (op_a[DATA_W-1] == op_b[DATA_W-1]) && (wr_data[DATA_W-1] != op_a[DATA_W-1])};
        end
        OP_SUB: begin
          wr_en = 1'b1; flag_we = 1'b1; wr_data = diff[DATA_W-1:0];
          flag_nxt = {wr_data[DATA_W-1], wr_data == '0, diff[DATA_W],
                      (op_a[DATA_W-1] != op_b[DATA_W-1]) && (wr_data[DATA_W-1] != op_a[DATA_W-1])};
        end
        default: ;
      endcase
    end else if (state == S_MUL && cnt == CNT_LAST) begin
      wr_en = 1'b1; sgpr_we = 1'b1; flag_we = 1'b1;
      wr_data  = prod_nxt[DATA_W-1:0];
      flag_nxt = {prod_nxt[2*DATA_W-1], prod_nxt == '0,
                  prod_nxt[2*DATA_W-1:DATA_W] != '0, 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      state    <= S_IDLE;
      op       <= '0;
      rdst     <= '0;
      imm_mode <= 1'b0;
      op_a     <= '0;
      op_b     <= '0;
      cnt      <= '0;
      prod     <= '0;
      done     <= 1'b0;
      illegal  <= 1'b0;
      flags    <= '0;
      sgpr     <= '0;
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else begin
      done    <= 1'b0;
      illegal <= 1'b0;
      case (state)
        S_IDLE: if (issue) begin
          op       <= instr_in[31:27];
          rdst     <= instr_in[26:22];
          imm_mode <= instr_in[16];
          op_a     <= regs[instr_in[21:17]];
          op_b     <= b_nxt;
          prod     <= {{DATA_W{1'b0}}, b_nxt};
          cnt      <= '0;
          state    <= (instr_in[31:27] == OP_MUL) ? S_MUL : S_EXEC;
        end
        S_EXEC: begin
          state   <= S_IDLE;
          done    <= 1'b1;
          illegal <= (op > OP_MUL);
        end
        S_MUL: begin
          prod <= prod_nxt;
          cnt  <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            state <= S_IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
      if (flag_we) flags <= flag_nxt;
      if (sgpr_we) sgpr  <= prod_nxt[2*DATA_W-1:DATA_W];
      for (int i = 0; i < GPR_DEPTH; i++)
        if (wr_en && rdst == 5'(i)) regs[i] <= wr_data;
    end
  end

endmodule

// File: tb/tb_gpr_exec_unit.sv
// Scoreboard bench for gpr_exec_unit: directed cases then random ops against an arithmetic model.
module tb_gpr_exec_unit;

  localparam int W     = 16;
  localparam int DEPTH = 24;

  logic          clk, sys_rst, instr_valid, instr_ready, done, illegal;
  logic [31:0]   instr_in;
  logic [3:0]    flags;
  logic [4:0]    dbg_addr;
  logic [W-1:0]  dbg_data, sgpr;

  gpr_exec_unit #(.DATA_W(W), .GPR_DEPTH(DEPTH), .IMM_SIGNED(1'b0)) dut (
    .clk(clk), .sys_rst(sys_rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_in(instr_in), .done(done), .illegal(illegal), .flags(flags),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data), .sgpr(sgpr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          rd;
    int unsigned val;
    logic [3:0]  flg;
    logic        ill;
    int unsigned sg;
    int          lat;
    int          issue_cyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          n_tests = 0, n_fail = 0, cyc = 0;
  int unsigned m_gpr [32];
  int unsigned m_sgpr;
  logic [3:0]  m_flags;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] enc(input int op, input int rd, input int rs1, input int imm, input int lo);
    return {5'(op), 5'(rd), 5'(rs1), 1'(imm), 16'(lo)};
  endfunction

  function automatic logic [31:0] enc_r(input int op, input int rd, input int rs1, input int rs2);
    return enc(op, rd, rs1, 0, (rs2 << 11) | int'($urandom_range(0, 2047)));
  endfunction

  function automatic int sgn(input int unsigned v);
    return (v >= 32768) ? int'(v) - 65536 : int'(v);
  endfunction

  function automatic int unsigned rdreg(input int idx);
    return (idx < DEPTH) ? m_gpr[idx] : 0;
  endfunction

  // Reference: architectural effect of one instruction, in plain integer arithmetic.
  task automatic model(input logic [31:0] ins, output exp_t e);
    int          op, rd, s;
    int unsigned a, b, r;
    longint unsigned p;
    logic        c, v, wr;
    op = int'(ins[31:27]);
    rd = int'(ins[26:22]);
    a  = rdreg(int'(ins[21:17]));
    b  = ins[16] ? int'(ins[15:0]) : rdreg(int'(ins[15:11]));
    c = 0; v = 0; r = 0; wr = 1;
    e.lat = 2;
    case (op)
      0: r = m_sgpr;
      1: r = ins[16] ? b : a;
      2: begin
        r = (a + b) % 65536; c = (a + b) > 65535;
        s = sgn(a) + sgn(b); v = (s > 32767) || (s < -32768);
      end
      3: begin
        r = (a + 65536 - b) % 65536; c = a < b;
        s = sgn(a) - sgn(b); v = (s > 32767) || (s < -32768);
      end
      4: begin
        p = longint'(a) * longint'(b);
        r = int'(p % 65536); m_sgpr = int'(p / 65536);
        e.lat = W + 1;
      end
      default: wr = 0;
    endcase
    if (wr) begin
      if (op == 4) m_flags = {p >= 64'h8000_0000, p == 0, m_sgpr != 0, 1'b0};
      else         m_flags = {r >= 32768, r == 0, c, v};
      if (rd < DEPTH) m_gpr[rd] = r;
    end
    e.rd  = rd;
    e.val = rdreg(rd);
    e.flg = m_flags;
    e.ill = !wr;
    e.sg  = m_sgpr;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_gpr[i] = 0;
    m_sgpr = 0; m_flags = 0;
  endtask

  // Called at a negedge; leaves instr_valid high with junk during the busy cycle to check it is ignored.
  task automatic issue(input logic [31:0] ins);
    exp_t e;
    int   n = 0;
    instr_valid = 1'b1;
    instr_in    = ins;
    while (instr_ready !== 1'b1 && n < 200) begin
      @(negedge clk); n++;
    end
    if (n >= 200) begin
      chk("issue_timeout", n, 0);
      instr_valid = 1'b0;
      return;
    end
    model(ins, e);
    e.issue_cyc = cyc;
    sb.push_back(e);
    @(negedge clk);
    instr_in = $urandom;
  endtask

  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        mon_e = sb.pop_front();
        chk("latency", cyc - mon_e.issue_cyc, mon_e.lat);
        chk("illegal", illegal, mon_e.ill);
        chk("flags", flags, mon_e.flg);
        chk("sgpr", sgpr, mon_e.sg);
        dbg_addr = 5'(mon_e.rd);
        #1;
        chk("gpr_rdst", dbg_data, mon_e.val);
      end
    end else if (illegal === 1'b1) chk("illegal_without_done", 1, 0);
  end

  initial begin
    int op, n;
    logic [31:0] ins;
    model_reset();
    sys_rst = 1'b1; instr_valid = 1'b0; instr_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", instr_ready, 1);
    chk("rst_done", done, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_flags", flags, 0);
    chk("rst_sgpr", sgpr, 0);
    sys_rst = 1'b0;

    issue(enc(1, 2, 0, 1, 2));          // MOVI R2=2
    issue(enc(2, 0, 2, 1, 4));          // ADI R0=R2+4 -> 6
    issue(enc(1, 4, 0, 1, 2));
    issue(enc(1, 5, 0, 1, 2));
    issue(enc_r(2, 0, 4, 5));           // R0=R4+R5 -> 4
    issue(enc_r(1, 4, 7, 0));           // MOV R4=R7 -> 0, zero
    issue(enc(1, 1, 0, 1, 2));
    issue(enc(1, 3, 0, 1, 3));
    issue(enc_r(3, 6, 1, 3));           // SUB -> FFFF, sign, borrow
    issue(enc(1, 1, 0, 1, 16'h7FFF));
    issue(enc(2, 1, 1, 1, 1));          // signed overflow
    issue(enc(1, 1, 0, 1, 16'h1234));
    issue(enc(1, 2, 0, 1, 16'h0100));
    issue(enc_r(4, 3, 1, 2));           // MUL -> R3=3400, sgpr=0012
    issue(enc(0, 4, 0, 0, 0));          // MOVSGPR R4
    issue(enc_r(31, 5, 1, 2));          // illegal
    issue(enc_r(1, 9, 30, 0));          // out-of-range source reads 0

    // Reset during a multiply: nothing retires, state cleared.
    issue(enc_r(4, 3, 1, 2));
    repeat (7) @(negedge clk);
    sys_rst = 1'b1; instr_valid = 1'b0;
    @(negedge clk);
    sys_rst = 1'b0;
    void'(sb.pop_back());
    model_reset();
    @(negedge clk);
    chk("midrst_ready", instr_ready, 1);
    chk("midrst_flags", flags, 0);
    chk("midrst_sgpr", sgpr, 0);
    issue(enc_r(1, 6, 3, 0));           // R3 must read 0 after reset
    issue(enc(0, 7, 0, 0, 0));

    for (int i = 0; i < 150; i++) begin
      op = $urandom_range(0, 6);
      if (op >= 5) op = $urandom_range(5, 31);
      if ($urandom_range(0, 1) == 1)
        ins = enc(op, $urandom_range(0, 31), $urandom_range(0, 25), 1, $urandom_range(0, 65535));
      else
        ins = enc_r(op, $urandom_range(0, 31), $urandom_range(0, 25), $urandom_range(0, 25));
      if (op == 4 && $urandom_range(0, 3) == 0) ins = enc_r(4, $urandom_range(0, 7), 0, 1);
      issue(ins);
      if ($urandom_range(0, 4) == 0) begin
        instr_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
    end

    instr_valid = 1'b0;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk); n++;
    end
    chk("drain_pending", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
